updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised up/down counter with a programmable terminal value, synchronous load, count enable, and selectable wrap or saturate behaviour at the boundaries. It is the general-purpose successor to the fixed 4-bit up/down counter. It is used wherever a datapath needs a bounded event counter, a programmable divider or a position tracker. Registered overflow/underflow pulses allow counters to be cascaded, or let a controller react to each boundary crossing.

## Interface
Parameters:
- WIDTH, default 8: counter width in bits, minimum 2.
- RST_VAL, default 0: value loaded into count on reset. Must be ≤ the limit value used after reset.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- en, input, 1: count enable; one step per cycle while high.
- mode, input, 1: direction; 1 = up, 0 = down.
- sat, input, 1: boundary behaviour; 1 = saturate, 0 = wrap.
- limit, input, WIDTH: terminal (maximum) value. The legal count range is 0..limit.
- load, input, 1: synchronous load strobe.
- load_val, input, WIDTH: value captured on load.
- count, output, WIDTH: registered counter value.
- ovf, output, 1: registered one-cycle pulse; an up step met the limit.
- unf, output, 1: registered one-cycle pulse; a down step met 0.
- at_max, output, 1: combinational; count ≥ limit.
- at_min, output, 1: combinational; count == 0.

## Operation
- Reset (rst low, asynchronous): count = RST_VAL, ovf = 0, unf = 0. All inputs are ignored while rst is low.
- Per-cycle priority is load > en > hold.
- Load:
  - count ← min(load_val, limit).
  - ovf and unf are 0 for that cycle.
  - en and mode are ignored in that cycle.
- Up step (en=1, mode=1):
  - If count < limit: count+1.
  - If count ≥ limit and sat=0: wrap, count ← 0, ovf=1.
  - If count ≥ limit and sat=1: count ← limit (clamps any out-of-range value), ovf=1.
- Down step (en=1, mode=0):
  - If count > 0: count−1. This applies even when count > limit, so a stale count decays toward the range.
  - If count == 0 and sat=0: wrap, count ← limit, unf=1.
  - If count == 0 and sat=1: count holds at 0, unf=1.
- Hold (en=0, load=0): count unchanged, ovf=unf=0.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - No intermediate carry bit is exposed.
  - limit = 0 is legal: every enabled step hits a boundary. Count stays at 0, and ovf or unf pulses on each enabled cycle depending on mode.
  - limit = 2^WIDTH−1 gives natural modulo-2^WIDTH behaviour.
- limit changes take effect on the next edge. No internal copy of limit is kept.
- ovf and unf are never high in the same cycle.
- Saturating steps at a boundary pulse ovf/unf on every enabled cycle. This lets software count blocked events.

## Timing
- Latency:
  - count reflects load or a step one edge after the inputs are sampled.
  - ovf/unf are high in the same cycle that the post-boundary count is visible, for exactly one cycle per boundary event.
- at_max/at_min follow count combinationally, and follow limit for at_max. There is no added latency.
- Reset deassertion is synchronous to clk at the integration level. The first step occurs on the first rising edge where rst is high and en=1.
- Reset asserted mid-count clears count to RST_VAL immediately, without waiting for clk, and clears any pending ovf/unf.
- mode, sat or en may change every cycle. Each cycle's step uses only the values sampled at that edge.

## Structure
- A shared package holds:
  - the mode constants MODE_UP=1'b1 and MODE_DOWN=1'b0;
  - the boundary constants BND_WRAP=1'b0 and BND_SAT=1'b1.
- The boundary arithmetic lives in one combinational sub-module, updown_step. Its inputs are count, limit, mode and sat; its outputs are next_count, hit_max and hit_min.
- The top level holds the registers, the load/en priority mux and the at_max/at_min compare.

## Test plan
All scenarios use WIDTH=4 and RST_VAL=0.
- Reset then count up: rst low→high, en=1, mode=1, limit=9, sat=0 → count 0,1,…,9,0. ovf pulses exactly in the cycle count shows 0 after 9.
- Count down with wrap: from 0, mode=0, limit=5, sat=0 → count 5,4,3,2,1,0,5. unf pulses with each transition to 5. at_min is high while count=0.
- Saturate at the limit: sat=1, limit=3, mode=1, 6 enabled cycles → count 1,2,3,3,3,3. ovf is high on the last 3 cycles. Switching to mode=0 then gives 2,1,0,0, with unf on the final cycle.
- Load priority and clamping:
  - load=1, load_val=12, limit=7, en=1 → count=7 next cycle, no ovf/unf.
  - load_val=4 with en=1 → count=4; the step is ignored.
- Limit shrink: count=8, limit changed to 5, mode=1, sat=0 → next count=0 with an ovf pulse. With mode=0 instead, next count=7.
- Async reset mid-run: count=6, assert rst between clock edges → count=0 and ovf=unf=0 before the next edge. Counting resumes from 0 after release.

Source files
------------

// File: rtl/updown_mod_counter_pkg.sv
// Shared constants for the up/down modulo counter: direction and boundary-mode encodings.
package updown_mod_counter_pkg;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  localparam logic BND_WRAP  = 1'b0;
  localparam logic BND_SAT   = 1'b1;

endpackage

// File: rtl/updown_step.sv
// Combinational boundary arithmetic: one up or down step of count within 0..limit.
module updown_step
  import updown_mod_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] limit,
  input  logic             mode,
  input  logic             sat,
  output logic [WIDTH-1:0] next_count,
  output logic             hit_max,
  output logic             hit_min
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    next_count = count;
    hit_max    = 1'b0;
    hit_min    = 1'b0;
    if (mode == MODE_UP) begin
      // count >= limit also catches a stale count left above a shrunk limit
      if (count < limit) begin
        next_count = count + ONE;
      end else begin
        hit_max    = 1'b1;
        next_count = (sat == BND_SAT) ? limit : '0;
      end
    end else begin
      if (count != '0) begin
        next_count = count - ONE;
      end else begin
        hit_min    = 1'b1;
        next_count = (sat == BND_SAT) ? '0 : limit;
      end
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter with programmable limit, load, enable and wrap/saturate boundaries.
module updown_mod_counter
  import updown_mod_counter_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             sat,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             unf,
  output logic             at_max,
  output logic             at_min
);

  logic [WIDTH-1:0] step_count;
  logic [WIDTH-1:0] load_clamped;
  logic             hit_max;
  logic             hit_min;

  updown_step #(.WIDTH(WIDTH)) u_step (
    .count      (count),
    .limit      (limit),
    .mode       (mode),
    .sat        (sat),
    .next_count (step_count),
    .hit_max    (hit_max),
    .hit_min    (hit_min)
  );

  assign load_clamped = (load_val > limit) ? limit : load_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= RST_VAL;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (en) begin
      count <= step_count;
      ovf   <= hit_max;
      unf   <= hit_min;
    end else begin
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end
  end

  assign at_max = (count >= limit);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomized and directed bench for updown_mod_counter against an integer reference model.
module tb_updown_mod_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, mode = 1'b0, sat = 1'b0, load = 1'b0;
  logic [W-1:0] limit = '0, load_val = '0;
  logic [W-1:0] count;
  logic         ovf, unf, at_max, at_min;

  int n_chk  = 0;
  int n_pass = 0;
  int m_cnt  = 0;
  int m_ovf  = 0;
  int m_unf  = 0;
  int m_lim  = 0;

  updown_mod_counter #(.WIDTH(W), .RST_VAL(4'd0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .sat      (sat),
    .limit    (limit),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .ovf      (ovf),
    .unf      (unf),
    .at_max   (at_max),
    .at_min   (at_min)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},  int'(count),  m_cnt);
    chk({tag, ".ovf"},    int'(ovf),    m_ovf);
    chk({tag, ".unf"},    int'(unf),    m_unf);
    chk({tag, ".at_max"}, int'(at_max), (m_cnt >= m_lim) ? 1 : 0);
    chk({tag, ".at_min"}, int'(at_min), (m_cnt == 0) ? 1 : 0);
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input string tag, input bit e, input bit m, input bit s,
                     input int lim, input bit ld, input int lv);
    en = e; mode = m; sat = s; limit = lim[W-1:0]; load = ld; load_val = lv[W-1:0];
    m_lim = lim;
    @(posedge clk);
    m_ovf = 0;
    m_unf = 0;
    if (ld) begin
      m_cnt = (lv > lim) ? lim : lv;
    end else if (e) begin
      if (m) begin
        if (m_cnt < lim) m_cnt = m_cnt + 1;
        else begin m_ovf = 1; m_cnt = s ? lim : 0; end
      end else begin
        if (m_cnt > 0) m_cnt = m_cnt - 1;
        else begin m_unf = 1; m_cnt = s ? 0 : lim; end
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #3 rst = 1'b0;
    #1;
    m_cnt = 0; m_ovf = 0; m_unf = 0;
    check_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2;
    m_lim = 0;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    repeat (11) cyc("up_wrap", 1, 1, 0, 9, 0, 0);
    repeat (7)  cyc("dn_wrap", 1, 0, 0, 5, 0, 0);
    cyc("sat_load0", 0, 1, 1, 3, 1, 0);
    repeat (6)  cyc("sat_up", 1, 1, 1, 3, 0, 0);
    repeat (4)  cyc("sat_dn", 1, 0, 1, 3, 0, 0);
    cyc("load_clamp", 1, 1, 0, 7, 1, 12);
    cyc("load_prio",  1, 1, 0, 7, 1, 4);
    cyc("shrink_ld",  0, 1, 0, 15, 1, 8);
    cyc("shrink_up",  1, 1, 0, 5, 0, 0);
    cyc("shrink_ld2", 0, 1, 0, 15, 1, 8);
    cyc("shrink_dn",  1, 0, 0, 5, 0, 0);
    cyc("hold",       0, 1, 0, 5, 0, 0);
    repeat (3) cyc("lim0_up", 1, 1, 0, 0, 0, 0);
    repeat (3) cyc("lim0_dn", 1, 0, 1, 0, 0, 0);
    cyc("full_ld", 0, 1, 0, 15, 1, 14);
    repeat (3) cyc("full_up", 1, 1, 0, 15, 0, 0);

    cyc("ar_ld", 0, 1, 0, 9, 1, 6);
    async_reset("ar_mid");
    repeat (2) cyc("ar_resume", 1, 1, 0, 9, 0, 0);
    cyc("ar_ld9", 0, 1, 0, 9, 1, 9);
    cyc("ar_ovf", 1, 1, 0, 9, 0, 0);
    async_reset("ar_clr_ovf");
    cyc("ar_resume2", 1, 1, 0, 9, 0, 0);

    begin
      int lim = 9;
      repeat (600) begin
        if ($urandom_range(7) == 0) lim = $urandom_range(15);
        if ($urandom_range(63) == 0) async_reset("rnd_rst");
        cyc("rnd", $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
            lim, $urandom_range(7) == 0, $urandom_range(15));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
